// File: rtl/sw_debounce_pkg.sv
// Shared state encodings and default sizing for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } db_state_e;

  localparam int DEF_NB_SW           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_NB_DB           = 20;

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: 4-state FSM with a settle counter and registered level/edge outputs.
module debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int NB_DB           = DEF_NB_DB
) (
  input  logic clock,
  input  logic i_reset,
  input  logic s,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt
);

  localparam logic [NB_DB-1:0] CNT_MAX = NB_DB'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [NB_DB-1:0] cnt_q, cnt_d;
  logic             sw_q, sw_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_RISE;
          cnt_d   = '0;
        end
      end
      ST_RISE: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          sw_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + NB_DB'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_FALL;
          cnt_d   = '0;
        end
      end
      ST_FALL: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          sw_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + NB_DB'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        sw_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_sw       = sw_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  // Exposed so the top can register o_valid in the same cycle as o_rise.
  assign o_rise_nxt = rise_d;

endmodule

// File: rtl/sw_debounce.sv
// Board switch input path: 2-FF synchronizer, per-bit debounce channels, any-press strobe.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int NB_SW           = DEF_NB_SW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int NB_DB           = DEF_NB_DB
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw_raw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall,
  output logic             o_valid
);

  logic [1:0][NB_SW-1:0] sync_q, sync_d;
  logic [NB_SW-1:0]      rise_nxt;
  logic                  valid_q, valid_d;

  always_comb begin
    sync_d[0] = i_sw_raw;
    sync_d[1] = sync_q[0];
    valid_d   = |rise_nxt;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < NB_SW; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .NB_DB          (NB_DB)
    ) u_chan (
      .clock     (clock),
      .i_reset   (i_reset),
      .s         (sync_q[1][i]),
      .o_sw      (o_sw[i]),
      .o_rise    (o_rise[i]),
      .o_fall    (o_fall[i]),
      .o_rise_nxt(rise_nxt[i])
    );
  end

  assign o_valid = valid_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed vector table, hand sequences and random holds vs a window model.
module tb_sw_debounce;
  localparam int NB_SW = 4;
  localparam int DB    = 4;
  localparam int NB_DB = 3;

  logic             clock = 1'b0;
  logic             i_reset = 1'b1;
  logic [NB_SW-1:0] i_sw_raw = 4'hF;
  logic [NB_SW-1:0] o_sw, o_rise, o_fall;
  logic             o_valid;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sw_debounce #(.NB_SW(NB_SW), .DEBOUNCE_CYCLES(DB), .NB_DB(NB_DB)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw_raw(i_sw_raw),
    .o_sw    (o_sw),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_valid (o_valid)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a level is accepted once the synchronized input (raw delayed two edges)
  // has held the same value over the last DB+1 sampling edges.
  logic [3:0] hist [DB+2];
  logic [3:0] m_sw, m_rise, m_fall;
  logic [3:0] nsw, ones, zeros;
  bit         m_en = 1'b0;

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      foreach (hist[j]) hist[j] = '0;
      m_sw = '0; m_rise = '0; m_fall = '0;
    end else begin
      ones = 4'hF; zeros = 4'hF;
      for (int k = 1; k <= DB + 1; k++) begin
        ones  = ones & hist[k];
        zeros = zeros & ~hist[k];
      end
      nsw    = (m_sw | ones) & ~zeros;
      m_rise = nsw & ~m_sw;
      m_fall = ~nsw & m_sw;
      m_sw   = nsw;
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = i_sw_raw;
    end
  end

  always @(negedge clock) begin
    if (m_en) begin
      chk("mdl_sw", o_sw, m_sw);
      chk("mdl_rise", o_rise, m_rise);
      chk("mdl_fall", o_fall, m_fall);
      chk("mdl_valid", {3'b0, o_valid}, {3'b0, |m_rise});
    end
  end

  typedef struct {
    logic [3:0] raw;
    int         n;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       valid;
    string      name;
  } vec_t;

  vec_t vt[$];

  task automatic chk_all(input string name, input logic [3:0] sw, input logic [3:0] rise,
                         input logic [3:0] fall, input logic valid);
    chk({name, "_sw"}, o_sw, sw);
    chk({name, "_rise"}, o_rise, rise);
    chk({name, "_fall"}, o_fall, fall);
    chk({name, "_valid"}, {3'b0, o_valid}, {3'b0, valid});
  endtask

  initial begin
    vt.push_back('{4'h1, 6, 4'h0, 4'h0, 4'h0, 1'b0, "press_wait"});
    vt.push_back('{4'h1, 1, 4'h1, 4'h1, 4'h0, 1'b1, "press_edge"});
    vt.push_back('{4'h1, 1, 4'h1, 4'h0, 4'h0, 1'b0, "press_end"});
    vt.push_back('{4'h0, 6, 4'h1, 4'h0, 4'h0, 1'b0, "rel_wait"});
    vt.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h1, 1'b0, "rel_edge"});
    vt.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h0, 1'b0, "rel_end"});
    vt.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h0, 1'b0, "idle_a"});
    vt.push_back('{4'h2, 2, 4'h0, 4'h0, 4'h0, 1'b0, "bnc_h1"});
    vt.push_back('{4'h0, 2, 4'h0, 4'h0, 4'h0, 1'b0, "bnc_l1"});
    vt.push_back('{4'h2, 2, 4'h0, 4'h0, 4'h0, 1'b0, "bnc_h2"});
    vt.push_back('{4'h0, 2, 4'h0, 4'h0, 4'h0, 1'b0, "bnc_l2"});
    vt.push_back('{4'h2, 6, 4'h0, 4'h0, 4'h0, 1'b0, "bnc_wait"});
    vt.push_back('{4'h2, 1, 4'h2, 4'h2, 4'h0, 1'b1, "bnc_edge"});
    vt.push_back('{4'h2, 1, 4'h2, 4'h0, 4'h0, 1'b0, "bnc_end"});
    vt.push_back('{4'h0, 6, 4'h2, 4'h0, 4'h0, 1'b0, "bnc_rel_wait"});
    vt.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h2, 1'b0, "bnc_rel_edge"});
    vt.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h0, 1'b0, "idle_b"});
    vt.push_back('{4'h4, 3, 4'h0, 4'h0, 4'h0, 1'b0, "glitch_hi"});
    vt.push_back('{4'h0, 10, 4'h0, 4'h0, 4'h0, 1'b0, "glitch_after"});
    vt.push_back('{4'hF, 6, 4'h0, 4'h0, 4'h0, 1'b0, "sim_wait"});
    vt.push_back('{4'hF, 1, 4'hF, 4'hF, 4'h0, 1'b1, "sim_edge"});
    vt.push_back('{4'hF, 1, 4'hF, 4'h0, 4'h0, 1'b0, "sim_end"});
    vt.push_back('{4'h0, 6, 4'hF, 4'h0, 4'h0, 1'b0, "sim_rel_wait"});
    vt.push_back('{4'h0, 1, 4'h0, 4'h0, 4'hF, 1'b0, "sim_rel_edge"});
    vt.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h0, 1'b0, "idle_c"});

    // Reset asserted between clock edges, with all raw inputs high.
    #3 i_reset = 1'b0;
    #1 m_en = 1'b1;
    chk_all("rst_async", 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1 chk_all("rst_held", 4'h0, 4'h0, 4'h0, 1'b0);
    i_sw_raw = 4'h0;
    i_reset  = 1'b1;
    @(posedge clock);
    #1;

    foreach (vt[i]) begin
      i_sw_raw = vt[i].raw;
      repeat (vt[i].n) @(posedge clock);
      #1 chk_all(vt[i].name, vt[i].sw, vt[i].rise, vt[i].fall, vt[i].valid);
    end

    // Reset mid-count on bit3, raw still high through release.
    i_sw_raw = 4'h8;
    repeat (5) @(posedge clock);
    #1 i_reset = 1'b0;
    #2 chk_all("midrst_async", 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clock);
    #1 chk_all("midrst_held", 4'h0, 4'h0, 4'h0, 1'b0);
    i_reset = 1'b1;
    repeat (6) @(posedge clock);
    #1 chk_all("midrst_wait", 4'h0, 4'h0, 4'h0, 1'b0);
    @(posedge clock);
    #1 chk_all("midrst_edge", 4'h8, 4'h8, 4'h0, 1'b1);
    @(posedge clock);
    #1 chk_all("midrst_end", 4'h8, 4'h0, 4'h0, 1'b0);

    // Random holds of varying length, flipping a few bits at a time.
    for (int r = 0; r < 400; r++) begin
      i_sw_raw = i_sw_raw ^ (4'($urandom) & 4'($urandom));
      repeat ($urandom_range(1, 9)) @(posedge clock);
      #1;
    end
    repeat (12) @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
